// File: rtl/la_ioring_ctrl.sv
// la_ioring_ctrl: serialises {addr,data} config frames onto an io ring with shift/latch strobes.
module la_ioring_ctrl #(
  parameter           PROP   = "DEFAULT",
  parameter int       RINGW  = 8,
  parameter int       NPADS  = 16,
  parameter int       CFGW   = 8,
  parameter int       SETTLE = 4,
  localparam int      ADDRW  = $clog2(NPADS),
  localparam int      FRAMEW = ADDRW + CFGW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [ADDRW-1:0] req_addr,
  input  logic [CFGW-1:0]  req_data,
  output logic             done,
  output logic             err,
  output logic             busy,
  output logic [RINGW-1:0] ring_out
);
  localparam int BW = $clog2(FRAMEW);
  localparam int CW = $clog2(SETTLE + 1);
  typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_LATCH, S_SETTLE, S_DONE} state_t;
  state_t r_state, w_state;
  logic [FRAMEW-1:0] r_frame, w_frame;
  logic [BW-1:0] r_bit, w_bit;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [2:0] r_ring, w_ring;
  logic r_phase, w_phase, r_done, r_err, r_busy, w_err, w_ok;
  always_comb begin
    w_state = r_state;
    w_frame = r_frame;
    w_bit = r_bit;
    w_phase = r_phase;
    w_cnt = r_cnt;
    w_err = 1'b0;
    w_ok = {1'b0, req_addr} < (ADDRW+1)'(NPADS);
    case (r_state)
      S_IDLE: if (req_valid) begin
        w_err = !w_ok;
        if (w_ok) begin
          w_state = S_SHIFT;
          w_frame = {req_addr, req_data};
          w_bit = '0;
          w_phase = 1'b0;
        end
      end
      S_SHIFT: begin
        w_phase = !r_phase;
        if (r_phase) begin
          w_bit = r_bit + 1'b1;
          if (r_bit == BW'(FRAMEW-1)) w_state = S_LATCH;
        end
      end
      S_LATCH: begin
        w_state = S_SETTLE;
        w_cnt = CW'(SETTLE);
      end
      S_SETTLE: begin
        w_cnt = r_cnt - 1'b1;
        if (r_cnt == CW'(1)) w_state = S_DONE;
      end
      default: w_state = S_IDLE;
    endcase
    // ring bits are computed from next-state values so the flops below present them in that state's cycle
    w_ring = {w_state == S_LATCH, w_state == S_SHIFT && w_phase,
              w_state == S_SHIFT && w_frame[BW'(FRAMEW-1) - w_bit]};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_frame <= '0;
      r_bit <= '0;
      r_phase <= 1'b0;
      r_cnt <= '0;
      r_ring <= '0;
      r_done <= 1'b0;
      r_err <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_state <= w_state;
      r_frame <= w_frame;
      r_bit <= w_bit;
      r_phase <= w_phase;
      r_cnt <= w_cnt;
      r_ring <= w_ring;
      r_done <= w_state == S_DONE;
      r_err <= w_err;
      r_busy <= w_state != S_IDLE;
    end
  end
  assign req_ready = r_state == S_IDLE && !reset;
  assign ring_out = RINGW'(r_ring);
  assign done = r_done;
  assign err = r_err;
  assign busy = r_busy;
endmodule

// File: tb/tb_la_ioring_ctrl.sv
// tb_la_ioring_ctrl: schedule-model checker plus directed frame scenarios for la_ioring_ctrl.
module tb_la_ioring_ctrl;
  logic clk = 0, reset = 1, req_valid = 0, req_valid2 = 0;
  logic [3:0] req_addr = 0, req_addr2 = 0;
  logic [7:0] req_data = 0, req_data2 = 0;
  logic req_ready, done, err, busy, req_ready2, done2, err2, busy2;
  logic [7:0] ring_out, ring_out2;
  int checks = 0, errors = 0;
  bit chk_en = 0;
  typedef struct packed {logic [2:0] ring; logic dn;} ent_t;
  ent_t sched[$];
  logic m_err = 0;

  la_ioring_ctrl #(.RINGW(8), .NPADS(16), .CFGW(8), .SETTLE(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .done(done), .err(err),
    .busy(busy), .ring_out(ring_out));
  la_ioring_ctrl #(.RINGW(8), .NPADS(12), .CFGW(8), .SETTLE(4)) dut2 (
    .clk(clk), .reset(reset), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_addr(req_addr2), .req_data(req_data2), .done(done2), .err(err2),
    .busy(busy2), .ring_out(ring_out2));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each accepted frame becomes a list of per-cycle expected outputs
  task automatic build(input logic [11:0] f);
    for (int i = 0; i < 12; i++) begin
      sched.push_back({2'b00, f[11-i], 1'b0});
      sched.push_back({2'b01, f[11-i], 1'b0});
    end
    sched.push_back({3'b100, 1'b0});
    repeat (4) sched.push_back({3'b000, 1'b0});
    sched.push_back({3'b000, 1'b1});
  endtask

  always @(posedge clk) begin
    m_err = 0;
    if (reset) sched.delete();
    else if (sched.size() > 0) void'(sched.pop_front());
    else if (req_valid) begin
      if (int'(req_addr) < 16) build({req_addr, req_data});
      else m_err = 1;
    end
  end

  always @(negedge clk) if (chk_en) begin
    ent_t e;
    e = sched.size() > 0 ? sched[0] : '0;
    chk("ring_out", 32'(ring_out), 32'(e.ring));
    chk("done", 32'(done), 32'(e.dn));
    chk("err", 32'(err), 32'(m_err));
    chk("busy", 32'(busy), 32'(sched.size() != 0));
    chk("req_ready", 32'(req_ready), 32'(sched.size() == 0 && !reset));
  end

  task automatic send(input logic [3:0] a, input logic [7:0] d, input bit hold);
    @(posedge clk); #1;
    req_valid = 1; req_addr = a; req_data = d;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready) begin
        @(posedge clk); #1;
        if (!hold) req_valid = 0;
        return;
      end
    end
    checks++; errors++;
    $display("FAIL send_timeout got busy want ready");
    req_valid = 0;
  endtask

  task automatic observe(input int n, input bit scr, output logic [11:0] bits,
                         output int nb1, output int nb2, output int dk);
    bits = '0; nb1 = 0; nb2 = 0; dk = 0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (ring_out[1]) begin bits = {bits[10:0], ring_out[0]}; nb1++; end
      if (ring_out[2]) nb2++;
      if (done && dk == 0) dk = k;
      if (scr) begin
        @(posedge clk); #1;
        req_data = 8'($urandom);
        req_addr = 4'($urandom);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [11:0] bits;
    int nb1, nb2, dk;
    repeat (2) @(posedge clk);
    #1 chk_en = 1;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_ring", 32'(ring_out), 0);
    chk("rst_busy", 32'(busy), 0);
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    chk("post_rst_ready", 32'(req_ready), 1);

    send(4'h5, 8'hA3, 0);
    observe(32, 0, bits, nb1, nb2, dk);
    chk("a3_bits", 32'(bits), 32'h5A3);
    chk("a3_shift_pulses", 32'(nb1), 12);
    chk("a3_latch_pulses", 32'(nb2), 1);
    chk("a3_latency", 32'(dk), 30);

    @(posedge clk); #1;
    req_valid2 = 1; req_addr2 = 4'hC; req_data2 = 8'hFF;
    @(posedge clk); #1 req_valid2 = 0;
    @(negedge clk);
    chk("oor_err", 32'(err2), 1);
    chk("oor_ring", 32'(ring_out2), 0);
    chk("oor_ready", 32'(req_ready2), 1);
    chk("oor_busy", 32'(busy2), 0);
    @(negedge clk);
    chk("oor_err_once", 32'(err2), 0);
    @(posedge clk); #1;
    req_valid2 = 1; req_addr2 = 4'hB;
    @(posedge clk); #1 req_valid2 = 0;
    @(negedge clk);
    chk("inrange_busy", 32'(busy2), 1);
    chk("inrange_err", 32'(err2), 0);

    send(4'h3, 8'h3C, 1);
    req_addr = 4'h9; req_data = 8'h5E;
    observe(31, 0, bits, nb1, nb2, dk);
    chk("b2b_first_bits", 32'(bits), 32'h33C);
    chk("b2b_first_done", 32'(dk), 30);
    @(posedge clk); #1 req_valid = 0;
    observe(30, 0, bits, nb1, nb2, dk);
    chk("b2b_second_bits", 32'(bits), 32'h95E);
    chk("b2b_second_done", 32'(dk), 30);

    send(4'h2, 8'h81, 0);
    observe(30, 1, bits, nb1, nb2, dk);
    chk("scramble_bits", 32'(bits), 32'h281);
    chk("scramble_done", 32'(dk), 30);

    send(4'h6, 8'hF0, 0);
    repeat (9) @(posedge clk);
    #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    chk("abort_ring", 32'(ring_out), 0);
    observe(40, 0, bits, nb1, nb2, dk);
    chk("abort_no_latch", 32'(nb2), 0);
    chk("abort_no_done", 32'(dk), 0);
    send(4'hA, 8'h55, 0);
    observe(30, 0, bits, nb1, nb2, dk);
    chk("recover_bits", 32'(bits), 32'hA55);
    chk("recover_done", 32'(dk), 30);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/la_ioring_ctrl.md
LA_IORING_CTRL -- requirements
Module: la_ioring_ctrl

Interface
REQ-001 The module SHALL have parameter PROP, default "DEFAULT", a cell property passed through and ignored functionally.
REQ-002 The module SHALL have parameter RINGW, default 8, the width of the io ring bus, minimum 3.
REQ-003 The module SHALL have parameter NPADS, default 16, the number of addressable pads on the ring.
REQ-004 The module SHALL have parameter CFGW, default 8, the number of config bits per pad.
REQ-005 The module SHALL have parameter SETTLE, default 4, the post-latch settle cycles, minimum 1.
REQ-006 The module SHALL derive localparam ADDRW = $clog2(NPADS) and FRAMEW = ADDRW+CFGW.
REQ-007 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-008 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-009 The module SHALL have port req_valid, input, 1 bit: config request valid.
REQ-010 The module SHALL have port req_ready, output, 1 bit: the controller can accept a request.
REQ-011 The module SHALL have port req_addr, input, ADDRW bits: target pad index.
REQ-012 The module SHALL have port req_data, input, CFGW bits: config word.
REQ-013 The module SHALL have port done, output, 1 bit: one-cycle pulse when a frame has completed.
REQ-014 The module SHALL have port err, output, 1 bit: one-cycle pulse when a request is rejected.
REQ-015 The module SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-016 The module SHALL have port ring_out, output, RINGW bits: drive onto the io ring.
REQ-017 In ring_out, bit0 SHALL be serial data, bit1 the shift strobe, bit2 the latch strobe, and bits RINGW-1:3 constant 0.

Function
REQ-018 The FSM SHALL have states IDLE, SHIFT, LATCH, SETTLE and DONE, each encoded as a register.
REQ-019 req_ready SHALL be 1 only in IDLE; a request is accepted on a cycle with req_valid&&req_ready.
REQ-020 On acceptance with req_addr<NPADS, the controller SHALL register frame={req_addr,req_data}, clear the bit/phase counters and go to SHIFT.
REQ-021 On acceptance with req_addr>=NPADS, the controller SHALL assert err for the next cycle only, stay in IDLE and leave ring_out at 0.
REQ-022 In SHIFT, each frame bit SHALL be sent MSB first over two cycles: phase A with data on bit0 and bit1=0, then phase B with the data held and bit1=1.
REQ-023 SHIFT SHALL last exactly 2*FRAMEW cycles, after which the FSM goes to LATCH.
REQ-024 LATCH SHALL last one cycle with bit2=1, bit1=0 and bit0=0.
REQ-025 SETTLE SHALL last SETTLE cycles with ring_out=0, counted by a down-counter loaded on entry.
REQ-026 DONE SHALL last one cycle with done=1, then the FSM returns to IDLE, where req_ready=1 on the following cycle.
REQ-027 Total latency from the acceptance edge to the done pulse SHALL be 2*FRAMEW+SETTLE+2 cycles.
REQ-028 req_valid, req_addr and req_data SHALL be ignored while busy; the registered frame SHALL not change mid-frame.
REQ-029 req_valid asserted in the same cycle as DONE SHALL not be accepted; it is accepted no earlier than the next cycle.
REQ-030 All ring_out bits SHALL be driven from registers, with no combinational path from inputs.

Reset
REQ-031 While reset=1 at a clock edge, the state SHALL go to IDLE, counters and the frame register to 0, ring_out=0, done=0, err=0 and busy=0.
REQ-032 req_ready SHALL be 0 during reset and 1 on the first cycle after reset is deasserted.
REQ-033 Reset asserted mid-SHIFT or mid-SETTLE SHALL abort the frame with no latch strobe and no done pulse.

Verification (NPADS=16, CFGW=8, SETTLE=4, so FRAMEW=12)
REQ-034 Request addr=0x5, data=0xA3 -> bit0 sequence 0101_10100011 over 24 cycles with 12 bit1 pulses, then one bit2 pulse, and done 30 cycles after acceptance.
REQ-035 With NPADS=12, request addr=0xC -> err pulses 1 cycle, ring_out stays 0, and req_ready is still 1.
REQ-036 Two back-to-back requests with req_valid held high -> the second is accepted the cycle after DONE, and the frames do not overlap.
REQ-037 Reset at cycle 10 of SHIFT -> ring_out=0 next cycle, no bit2 pulse, no done, and a new request completes normally.
REQ-038 Changing req_data while busy -> the shifted bits match the value captured at acceptance.
